// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end with one-outstanding memory requests,
// a prefetch FIFO feeding decode, branch redirect flush and halt-address stop.
module ifetch_queue #(
    parameter int         INSTR_W   = 32,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] HALT_ADDR = 8'd255
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [7:0]         mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [7:0]         instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [7:0]         redirect_pc,
    output logic               halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {FETCH, WAIT, STOP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         fetch_pc_q, fetch_pc_d;
    logic [7:0]         mem_addr_q, mem_addr_d;
    logic               mem_req_q, mem_req_d;
    logic               drop_q, drop_d;
    logic               halted_q, halted_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [INSTR_W-1:0] data_d [DEPTH];
    logic [7:0]         pc_q [DEPTH];
    logic [7:0]         pc_d [DEPTH];
    logic               ack, push, pop, outstanding;

    assign outstanding = state_q == WAIT;
    assign ack         = mem_req_q & mem_ack;
    assign push        = ack & ~drop_q & ~redirect;
    assign pop         = instr_valid & instr_ready & ~redirect;

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign halted      = halted_q;
    assign instr_valid = count_q != '0;
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_d     = data_q;
        pc_d       = pc_q;
        if (push) begin
            data_d[wr_ptr_q] = mem_rdata;
            pc_d[wr_ptr_q]   = mem_addr_q;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            fetch_pc_d       = mem_addr_q + 8'd1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        case (state_q)
            FETCH: begin
                if (fetch_pc_q == HALT_ADDR)
                    state_d = STOP;
                else if ((count_q + CW'(outstanding)) < CW'(DEPTH)) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (ack) begin
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    state_d   = FETCH;
                end
            end
            default: ;
        endcase
        // A redirect must still let an in-flight request finish on the bus
        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
            if (outstanding && !ack)
                drop_d = 1'b1;
            else begin
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
                state_d   = (redirect_pc == HALT_ADDR) ? STOP : FETCH;
            end
        end
        halted_d = (state_d == STOP) && (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            drop_q     <= 1'b0;
            halted_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '{default: '0};
            pc_q       <= '{default: '0};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue with a simple memory responder
// and logs of completed fetches and deliveries.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;
    logic        ack_en;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  acked[$];
    logic [7:0]  got_pc[$];
    logic [31:0] got_data[$];

    ifetch_queue dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] a);
        return 32'hC0DE_0000 | {24'h0, a};
    endfunction

    // Memory acks whenever enabled and a request is up
    always @(posedge clk) begin
        #2;
        mem_ack   = ack_en & mem_req & ~reset;
        mem_rdata = word(mem_addr);
    end

    always @(negedge clk) begin
        if (!reset && mem_req && mem_ack) acked.push_back(mem_addr);
        if (!reset && instr_valid && instr_ready && !redirect) begin
            got_pc.push_back(instr_pc);
            got_data.push_back(instr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!mem_req && n < 50) begin
            step(1);
            n++;
        end
        chk({tag, "_req"}, {31'h0, mem_req}, 32'h1);
        chk(tag, {24'h0, mem_addr}, {24'h0, exp});
    endtask

    task automatic clear_logs();
        acked.delete();
        got_pc.delete();
        got_data.delete();
    endtask

    initial begin
        reset = 1'b1; ack_en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(3);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc", {24'h0, instr_pc}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        reset = 1'b0;
        step(1);
        chk("first_req", {31'h0, mem_req}, 32'h1);
        chk("first_addr", {24'h0, mem_addr}, 32'h0);
        step(2);
        chk("hold_req", {31'h0, mem_req}, 32'h1);
        chk("hold_addr", {24'h0, mem_addr}, 32'h0);

        ack_en = 1'b1; instr_ready = 1'b1;
        step(16);
        chk("seq_nacks", {31'h0, acked.size() >= 4}, 32'h1);
        chk("seq_npops", {31'h0, got_pc.size() >= 4}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq_addr%0d", i), {24'h0, acked[i]}, i);
            chk($sformatf("seq_pc%0d", i), {24'h0, got_pc[i]}, i);
            chk($sformatf("seq_data%0d", i), got_data[i], word(8'(i)));
        end

        wait_req("pre_rst", mem_addr);
        reset = 1'b1;
        #1;
        chk("midrst_req", {31'h0, mem_req}, 32'h0);
        chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
        step(2);
        reset = 1'b0; instr_ready = 1'b0; ack_en = 1'b1;
        clear_logs();
        step(1);
        chk("post_rst_req", {31'h0, mem_req}, 32'h1);
        chk("post_rst_addr", {24'h0, mem_addr}, 32'h0);

        step(19);
        chk("full_nacks", acked.size(), 32'h4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("full_addr%0d", i), {24'h0, acked[i]}, i);
        chk("full_req", {31'h0, mem_req}, 32'h0);
        chk("full_valid", {31'h0, instr_valid}, 32'h1);
        chk("full_pc", {24'h0, instr_pc}, 32'h0);
        chk("full_data", instr, word(8'h00));

        ack_en = 1'b0; instr_ready = 1'b1;
        wait_req("resume4", 8'h04);
        ack_en = 1'b1;
        step(1);
        ack_en = 1'b0;
        wait_req("wait5", 8'h05);
        redirect = 1'b1; redirect_pc = 8'h40;
        step(1);
        redirect = 1'b0;
        clear_logs();
        chk("redir_hold_req", {31'h0, mem_req}, 32'h1);
        chk("redir_hold_addr", {24'h0, mem_addr}, 32'h5);
        chk("redir_flush", {31'h0, instr_valid}, 32'h0);
        ack_en = 1'b1;
        step(1);
        chk("redir_drop_req", {31'h0, mem_req}, 32'h0);
        chk("redir_drop_valid", {31'h0, instr_valid}, 32'h0);
        wait_req("redir_next", 8'h40);
        step(8);
        chk("redir_pc0", {24'h0, got_pc[0]}, 32'h40);
        chk("redir_data0", got_data[0], word(8'h40));
        chk("redir_pc1", {24'h0, got_pc[1]}, 32'h41);

        redirect = 1'b1; redirect_pc = 8'd253;
        step(1);
        redirect = 1'b0;
        clear_logs();
        step(20);
        chk("halt_nacks", acked.size(), 32'h2);
        chk("halt_a0", {24'h0, acked[0]}, 32'd253);
        chk("halt_a1", {24'h0, acked[1]}, 32'd254);
        chk("halt_npops", got_pc.size(), 32'h2);
        chk("halt_p0", {24'h0, got_pc[0]}, 32'd253);
        chk("halt_p1", {24'h0, got_pc[1]}, 32'd254);
        chk("halt_req", {31'h0, mem_req}, 32'h0);
        chk("halted", {31'h0, halted}, 32'h1);

        redirect = 1'b1; redirect_pc = 8'h10;
        step(1);
        redirect = 1'b0; instr_ready = 1'b0;
        clear_logs();
        chk("unhalt", {31'h0, halted}, 32'h0);
        wait_req("unhalt_addr", 8'h10);
        for (int n = 0; n < 40 && !(acked.size() == 2 && mem_req); n++)
            step(1);
        chk("cnt2_nacks", acked.size(), 32'h2);
        chk("cnt2_addr", {24'h0, mem_addr}, 32'h12);
        chk("cnt2_valid", {31'h0, instr_valid}, 32'h1);
        chk("cnt2_pc", {24'h0, instr_pc}, 32'h10);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'h80;
        step(1);
        redirect = 1'b0; instr_ready = 1'b0;
        chk("same_edge_valid", {31'h0, instr_valid}, 32'h0);
        chk("same_edge_req", {31'h0, mem_req}, 32'h0);
        wait_req("same_edge_next", 8'h80);
        step(3);
        chk("after_same_pc", {24'h0, instr_pc}, 32'h80);
        chk("after_same_data", instr, word(8'h80));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
